// File: rtl/i2s_pkg.sv
// Shared I2S transmit definitions: word-select encoding, frame geometry and
// the left/right sample pair type.
package i2s_pkg;

   localparam logic WS_LEFT  = 1'b0;
   localparam logic WS_RIGHT = 1'b1;

   localparam int unsigned PCM_W = 16;

   // Slots per frame: one per bit of the left word plus one per bit of the right word.
   function automatic int unsigned frame_slots(input int unsigned w);
      return 2 * w;
   endfunction

   typedef struct packed {
      logic signed [PCM_W-1:0] l;
      logic signed [PCM_W-1:0] r;
   } pcm_pair_t;

endpackage

// File: rtl/i2s_tx_if.sv
// Sample handshake and I2S line bundle between a PCM producer and i2s_tx.
interface i2s_tx_if #(
   parameter int unsigned WIDTH = 16
);
   logic signed [WIDTH-1:0] sample_l;
   logic signed [WIDTH-1:0] sample_r;
   logic                    sample_valid;
   logic                    sample_ready;
   logic                    i2s_bclk;
   logic                    i2s_ws;
   logic                    i2s_data;
   logic                    frame_start;
   logic                    underrun;

   // PCM producer side
   modport master (
      output sample_l, sample_r, sample_valid,
      input  sample_ready, i2s_bclk, i2s_ws, i2s_data, frame_start, underrun
   );

   // Transmitter side
   modport slave (
      input  sample_l, sample_r, sample_valid,
      output sample_ready, i2s_bclk, i2s_ws, i2s_data, frame_start, underrun
   );
endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk by 2*CLK_DIV and flags the clk edge on
// which BCLK rises or falls.
module i2s_bclk_gen #(
   parameter int unsigned CLK_DIV = 8
) (
   input  logic clk,
   input  logic reset,
   output logic bclk_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          bclk_q, bclk_d;
   logic          wrap;

   // Half-period counter; BCLK toggles on the wrap.
   always_comb begin
      wrap   = (cnt_q == CW'(CLK_DIV - 1));
      cnt_d  = wrap ? '0 : cnt_q + CW'(1);
      bclk_d = wrap ? ~bclk_q : bclk_q;
   end

   // Divider and BCLK state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         bclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         bclk_q <= bclk_d;
      end
   end

   assign bclk_o = bclk_q;
   assign rise_o = wrap & ~bclk_q;
   assign fall_o = wrap &  bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S (Philips) master transmitter: one-deep pending buffer fed by a
// valid/ready handshake, serialised MSB first with WS leading by one BCLK.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int unsigned CLK_DIV = 8,
   parameter int unsigned WIDTH   = 16
) (
   input logic      clk,
   input logic      reset,
   i2s_tx_if.slave  bus
);
   localparam int unsigned SLOTS = frame_slots(WIDTH);
   localparam int unsigned SW    = $clog2(SLOTS);

   typedef struct packed {
      logic signed [WIDTH-1:0] l;
      logic signed [WIDTH-1:0] r;
   } pair_t;

   logic bclk, bclk_rise, bclk_fall;

   i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
      .clk    (clk),
      .reset  (reset),
      .bclk_o (bclk),
      .rise_o (bclk_rise),
      .fall_o (bclk_fall)
   );

   logic [SW-1:0]        slot_q, slot_d;
   pair_t                pend_q, pend_d;
   logic                 pend_full_q, pend_full_d;
   logic                 ready_q, ready_d;
   logic [2*WIDTH-1:0]   shreg_q, shreg_d;
   logic [2*WIDTH-1:0]   frame_bits;
   logic                 ws_q, ws_d;
   logic                 data_q, data_d;
   logic                 fs_q, fs_d;
   logic                 und_q, und_d;
   logic                 accept, load;

   // Next-state: frame load, slot advance, serialiser and pending buffer.
   // The load inspects pending before this edge's accept, so a pair offered
   // in the load cycle itself waits for the next frame.
   always_comb begin
      accept      = bus.sample_valid & ready_q;
      load        = bclk_fall & (slot_q == SW'(SLOTS - 1));
      slot_d      = slot_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      shreg_d     = shreg_q;
      ws_d        = ws_q;
      data_d      = data_q;
      fs_d        = load;
      und_d       = und_q;
      frame_bits  = shreg_q;

      if (load) begin
         if (pend_full_q) begin
            frame_bits  = pend_q;
            pend_full_d = 1'b0;
         end else begin
            frame_bits = '0;
            und_d      = 1'b1;
         end
      end

      if (bclk_fall) begin
         slot_d  = (slot_q == SW'(SLOTS - 1)) ? '0 : slot_q + SW'(1);
         data_d  = frame_bits[2*WIDTH-1];
         shreg_d = frame_bits << 1;
         ws_d    = (slot_d >= SW'(WIDTH - 1) && slot_d <= SW'(SLOTS - 2)) ? WS_RIGHT : WS_LEFT;
      end

      if (accept) begin
         pend_d      = '{l: bus.sample_l, r: bus.sample_r};
         pend_full_d = 1'b1;
      end

      ready_d = ~pend_full_d;
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q      <= SW'(SLOTS - 1);
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         ready_q     <= 1'b1;
         shreg_q     <= '0;
         ws_q        <= WS_LEFT;
         data_q      <= 1'b0;
         fs_q        <= 1'b0;
         und_q       <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         ready_q     <= ready_d;
         shreg_q     <= shreg_d;
         ws_q        <= ws_d;
         data_q      <= data_d;
         fs_q        <= fs_d;
         und_q       <= und_d;
      end
   end

   // BCLK cannot rise and fall on the same clk edge.
   a_strobe_excl: assert property (@(posedge clk) disable iff (reset) !(bclk_rise && bclk_fall));

   assign bus.sample_ready = ready_q;
   assign bus.i2s_bclk     = bclk;
   assign bus.i2s_ws       = ws_q;
   assign bus.i2s_data     = data_q;
   assign bus.frame_start  = fs_q;
   assign bus.underrun     = und_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: cycle-exact reset/first-frame checks, a
// vector table of frames, handshake corner cases, backpressure, mid-frame
// reset and a CLK_DIV=4 loopback into a WS-edge I2S receiver.
module tb_i2s_tx;
   import i2s_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   i2s_tx_if #(.WIDTH(16)) bus ();
   i2s_tx_if #(.WIDTH(16)) lbus ();

   i2s_tx #(.CLK_DIV(8), .WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   i2s_tx #(.CLK_DIV(4), .WIDTH(16)) dut_lb (
      .clk   (clk),
      .reset (reset),
      .bus   (lbus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Cycles since reset release: at the negedge after the k-th released edge, cyc == k.
   int cyc = 0;
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      bus.sample_valid = 1'b0;
      lbus.sample_valid = 1'b0;
      wait_neg(n);
      reset = 1'b0;
   endtask

   task automatic wait_fs(input int limit);
      int n;
      n = 0;
      do begin
         wait_neg(1);
         n++;
      end while (!bus.frame_start && n < limit);
      check("fs_arrives", 32'(bus.frame_start), 32'd1);
   endtask

   // Scoreboard of expected 32-bit frames {L,R}, one entry per transmitted frame.
   logic [31:0] exp_q[$];

   // Main receiver: frames delimited by frame_start, bits taken on BCLK rises.
   logic        prev_bclk = 1'b0;
   logic        rx_act = 1'b0;
   int          nbits = 0;
   int          last_fs = -1;
   logic [31:0] rx_d = '0;
   logic [31:0] rx_ws = '0;
   logic [31:0] e;
   always @(negedge clk) begin
      if (reset) begin
         prev_bclk = 1'b0;
         rx_act = 1'b0;
         last_fs = -1;
      end else begin
         if (bus.frame_start) begin
            if (rx_act) check("frame_complete", 32'(nbits), 32'd32);
            if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'd512);
            last_fs = cyc;
            rx_act = 1'b1;
            nbits = 0;
         end
         if (rx_act && bus.i2s_bclk && !prev_bclk) begin
            rx_d  = {rx_d[30:0], bus.i2s_data};
            rx_ws = {rx_ws[30:0], bus.i2s_ws};
            nbits++;
            if (nbits == 32) begin
               rx_act = 1'b0;
               check("ws_pattern", rx_ws, 32'h0001_FFFE);
               check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("frame_data", rx_d, e);
               end
            end
         end
         prev_bclk = bus.i2s_bclk;
      end
   end

   // Loopback receiver: word boundaries found from WS transitions only.
   logic        lb_prev_bclk = 1'b0;
   logic        lb_prev_ws = WS_LEFT;
   logic [15:0] lb_sr = '0, lb_l = '0, lb_r = '0;
   always @(negedge clk) begin
      if (reset) begin
         lb_prev_bclk = 1'b0;
         lb_prev_ws = WS_LEFT;
         lb_sr = '0;
         lb_l = '0;
         lb_r = '0;
      end else begin
         if (lbus.i2s_bclk && !lb_prev_bclk) begin
            lb_sr = {lb_sr[14:0], lbus.i2s_data};
            if (lbus.i2s_ws != lb_prev_ws) begin
               if (lb_prev_ws == WS_LEFT) lb_l = lb_sr;
               else lb_r = lb_sr;
            end
            lb_prev_ws = lbus.i2s_ws;
         end
         lb_prev_bclk = lbus.i2s_bclk;
      end
   end

   typedef struct {
      logic        push;
      logic [15:0] l;
      logic [15:0] r;
      logic [31:0] exp_frame;
      logic        exp_und;
   } vec_t;

   vec_t      tbl[5];
   pcm_pair_t bp;
   int        k, acc, lb_acc;
   logic      adv, rdy_prev;

   initial begin
      tbl[0] = '{1'b1, 16'h1234, 16'h5678, 32'h1234_5678, 1'b1};
      tbl[1] = '{1'b1, 16'hFFFF, 16'h0000, 32'hFFFF_0000, 1'b1};
      tbl[2] = '{1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 1'b1};
      tbl[3] = '{1'b1, 16'h8000, 16'h7FFF, 32'h8000_7FFF, 1'b1};
      tbl[4] = '{1'b1, 16'h0001, 16'hFFFE, 32'h0001_FFFE, 1'b1};

      bus.sample_l = '0;  bus.sample_r = '0;  bus.sample_valid = 1'b0;
      lbus.sample_l = '0; lbus.sample_r = '0; lbus.sample_valid = 1'b0;

      // Reset values and first frame
      do_reset(3);
      check("rst_bclk", 32'(bus.i2s_bclk), 0);
      check("rst_ws", 32'(bus.i2s_ws), 0);
      check("rst_data", 32'(bus.i2s_data), 0);
      check("rst_ready", 32'(bus.sample_ready), 1);
      check("rst_underrun", 32'(bus.underrun), 0);
      check("rst_fs", 32'(bus.frame_start), 0);
      wait_neg(1);
      bus.sample_l = 16'hA5C3; bus.sample_r = 16'h8001; bus.sample_valid = 1'b1;
      exp_q.push_back(32'hA5C3_8001);
      wait_neg(1);
      bus.sample_valid = 1'b0;
      check("ready_low_after_accept", 32'(bus.sample_ready), 0);
      wait_neg(5);
      check("bclk_before_rise", 32'(bus.i2s_bclk), 0);
      wait_neg(1);
      check("first_rise_c8", 32'(bus.i2s_bclk), 1);
      wait_neg(7);
      check("no_fs_c15", 32'(bus.frame_start), 0);
      wait_neg(1);
      check("first_fall_c16", 32'(bus.i2s_bclk), 0);
      check("fs_c16", 32'(bus.frame_start), 1);
      check("msb_c16", 32'(bus.i2s_data), 1);
      check("ready_after_load", 32'(bus.sample_ready), 1);
      check("no_underrun_f0", 32'(bus.underrun), 0);

      // Underrun on frame 1
      exp_q.push_back(32'h0);
      wait_neg(511);
      check("underrun_before_f1", 32'(bus.underrun), 0);
      wait_neg(1);
      check("fs_c528", 32'(bus.frame_start), 1);
      check("underrun_f1", 32'(bus.underrun), 1);

      // Vector table, one frame per record
      for (int i = 0; i < 5; i++) begin
         if (tbl[i].push) begin
            bus.sample_l = tbl[i].l; bus.sample_r = tbl[i].r; bus.sample_valid = 1'b1;
            check("vec_ready", 32'(bus.sample_ready), 1);
            wait_neg(1);
            bus.sample_valid = 1'b0;
            check("vec_accepted", 32'(bus.sample_ready), 0);
         end
         exp_q.push_back(tbl[i].exp_frame);
         wait_fs(600);
         check("vec_underrun", 32'(bus.underrun), 32'(tbl[i].exp_und));
      end
      wait_fs(600);
      check("sb_drained_tbl", 32'(exp_q.size()), 0);

      // Pair accepted one cycle before the load edge is transmitted
      do_reset(2);
      wait_neg(14);
      bus.sample_l = 16'h1357; bus.sample_r = 16'h2468; bus.sample_valid = 1'b1;
      exp_q.push_back(32'h1357_2468);
      wait_neg(1);
      bus.sample_valid = 1'b0;
      check("late_accept_ready", 32'(bus.sample_ready), 0);
      wait_neg(1);
      check("late_accept_fs", 32'(bus.frame_start), 1);
      check("late_accept_no_underrun", 32'(bus.underrun), 0);
      check("late_accept_ready_back", 32'(bus.sample_ready), 1);

      // Pair offered in the load cycle with pending empty: silence now, pair next frame
      wait_neg(511);
      bus.sample_l = 16'hABCD; bus.sample_r = 16'h1111; bus.sample_valid = 1'b1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'hABCD_1111);
      wait_neg(1);
      bus.sample_valid = 1'b0;
      check("loadcyc_fs", 32'(bus.frame_start), 1);
      check("loadcyc_underrun", 32'(bus.underrun), 1);
      check("loadcyc_pending", 32'(bus.sample_ready), 0);
      wait_fs(600);
      check("loadcyc_ready_after", 32'(bus.sample_ready), 1);
      wait_fs(600);
      check("sb_drained_loadcyc", 32'(exp_q.size()), 0);

      // Backpressure: valid held high with incrementing pairs
      do_reset(2);
      k = 1; acc = 0; rdy_prev = 1'b1;
      bus.sample_l = 16'(k); bus.sample_r = 16'(k + 1); bus.sample_valid = 1'b1;
      for (int c = 0; c < 1600; c++) begin
         adv = bus.sample_ready;
         if (adv) begin
            bp.l = 16'(k); bp.r = 16'(k + 1);
            exp_q.push_back(bp);
            acc++;
         end
         rdy_prev = bus.sample_ready;
         wait_neg(1);
         if (adv) begin
            k += 2;
            bus.sample_l = 16'(k); bus.sample_r = 16'(k + 1);
         end
         if (bus.frame_start) begin
            check("one_accept_per_frame", 32'(acc), 1);
            check("ready_low_before_load", 32'(rdy_prev), 0);
            acc = 0;
         end
      end
      bus.sample_valid = 1'b0;
      wait_fs(600);
      check("bp_no_underrun", 32'(bus.underrun), 0);
      wait_fs(600);
      check("sb_drained_bp", 32'(exp_q.size()), 0);

      // Reset at slot 10 with a pair pending: pair and partial frame dropped
      wait_neg(80);
      bus.sample_l = 16'hDEAD; bus.sample_r = 16'hBEEF; bus.sample_valid = 1'b1;
      wait_neg(1);
      bus.sample_valid = 1'b0;
      check("midrst_pending_full", 32'(bus.sample_ready), 0);
      wait_neg(79);
      reset = 1'b1;
      wait_neg(1);
      check("midrst_bclk", 32'(bus.i2s_bclk), 0);
      check("midrst_ws", 32'(bus.i2s_ws), 0);
      check("midrst_data", 32'(bus.i2s_data), 0);
      check("midrst_fs", 32'(bus.frame_start), 0);
      check("midrst_underrun", 32'(bus.underrun), 0);
      check("midrst_ready", 32'(bus.sample_ready), 1);
      wait_neg(1);
      reset = 1'b0;
      exp_q.push_back(32'h0);
      wait_neg(16);
      check("midrst_fs_c16", 32'(bus.frame_start), 1);
      check("midrst_underrun_after", 32'(bus.underrun), 1);
      wait_fs(600);
      check("sb_drained_midrst", 32'(exp_q.size()), 0);

      // Loopback at CLK_DIV=4: two pushes of the same pair, WS-edge receiver
      do_reset(2);
      lb_acc = 0;
      lbus.sample_l = 16'h7FFF; lbus.sample_r = 16'h8000; lbus.sample_valid = 1'b1;
      for (int c = 0; c < 518; c++) begin
         if (lbus.sample_valid && lbus.sample_ready) lb_acc++;
         wait_neg(1);
         if (lb_acc == 2) lbus.sample_valid = 1'b0;
      end
      check("lb_accepts", 32'(lb_acc), 2);
      check("lb_no_underrun", 32'(lbus.underrun), 0);
      check("lb_left", 32'(lb_l), 32'h7FFF);
      check("lb_right", 32'(lb_r), 32'h8000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter, Philips format: the transmit end of the user-port audio link that the menu core already receives on.
- Serialises 16-bit left/right PCM pairs onto BCLK/WS/DATA, so a core can drive an external DAC or MT32-pi-style peer over USER_OUT.
- Samples arrive over a valid/ready handshake into a one-deep pending buffer.
- BCLK and WS are generated internally from the audio clock.

Parameters:
- CLK_DIV, 8: clk cycles per BCLK half-period. Must be ≥2. Default gives 24.576 MHz / 16 = 1.536 MHz BCLK, i.e. 48 kHz × 32.
- WIDTH, 16: sample width and bits per channel slot. A frame is 2×WIDTH BCLKs.

Ports:
- clk, in, 1: audio clock (CLK_AUDIO domain).
- reset, in, 1: synchronous, active-high.
- sample_l, in, WIDTH: left sample, signed.
- sample_r, in, WIDTH: right sample, signed.
- sample_valid, in, 1: sample pair offered.
- sample_ready, out, 1: pending buffer empty; a pair can be accepted.
- i2s_bclk, out, 1: bit clock.
- i2s_ws, out, 1: word select, 0 = left, 1 = right.
- i2s_data, out, 1: serial data, MSB first.
- frame_start, out, 1: one-cycle pulse when a new pair is loaded into the shifter.
- underrun, out, 1: sticky; set when a frame starts with no pending pair.

Behaviour:
- **Clocking.** One clock, clk. Reset is synchronous, active-high.
- **Reset values.** i2s_bclk=0, i2s_ws=0, i2s_data=0, frame_start=0, underrun=0, sample_ready=1. Pending buffer empty, slot=2×WIDTH−1, divider count=0.
- **Divider.**
  - Counter runs 0..CLK_DIV−1. At CLK_DIV−1 it wraps and toggles i2s_bclk.
  - A 1→0 toggle is a "fall event"; a 0→1 toggle is a "rise event".
  - The first rise is CLK_DIV cycles after reset release; the first fall is 2×CLK_DIV cycles after.
- **Slot counter.** s runs 0..2W−1 (W=WIDTH). It advances by one on each fall event and wraps 2W−1→0.
- **Output timing.** i2s_ws and i2s_data are registered and update on the same clk edge as the fall event, so the receiver samples them on the rising edge.
- **WS.** 1 for s in W−1..2W−2; 0 for s in 2W−1 and 0..W−2. WS therefore leads the MSB of each word by one BCLK.
- **Data.** s=0..W−1 → L[W−1−s]. s=W..2W−1 → R[2W−1−s].
- **Frame load, on the fall event that enters s=0.**
  - If the pending buffer is full: copy the pending pair to the shift registers, clear pending, pulse frame_start for 1 cycle.
  - Else: load zeros (silence), set underrun, pulse frame_start.
  - underrun clears only on reset.
- **Handshake.**
  - Accept when sample_valid & sample_ready, on a clk edge. The accepted pair goes into pending; pending becomes full.
  - sample_ready is registered and equals ~pending_full. There is no bypass.
  - When the load and a pending clear coincide, ready rises on the next cycle.
  - If pending is empty and valid rises in the load cycle itself, the load still sees empty (underrun). The pair stays pending for the next frame.
  - The bench must confirm that a pair accepted one cycle before the load edge is used.
- **First frame.** The first fall event after reset enters s=0, so a pair pushed within 2×CLK_DIV−1 cycles of reset release is transmitted in frame 0.
- **Reset mid-frame.** All state returns to reset values on the next edge. The pending pair and the partial frame are discarded; no tail bits are emitted.
- **Frame period.** 4×W×CLK_DIV clk cycles (512 at defaults). Slot wrap must be exact, with no extra BCLK.

Decomposition:
- Shared package i2s_pkg holds:
  - the WS encoding constants WS_LEFT=0 and WS_RIGHT=1;
  - the slot-count function frame_slots(W)=2W;
  - a packed struct for the sample pair {l, r}.
- One natural sub-module, i2s_bclk_gen. It contains the divider and the bclk register and emits the rise/fall strobes. The receiver-side debouncer can reuse it for test loopback.

Test Plan:
- **Reset.** Hold reset 3 cycles, then release → bclk=0, ws=0, data=0, sample_ready=1, underrun=0. First bclk rise at cycle 8, first fall at cycle 16.
- **Single frame.** Push L=16'hA5C3, R=16'h8001 at cycle 2 → frame_start at cycle 16. Bit model on rising edges reads ws=0 and data A5C3 MSB-first, then ws=1 and 8001. ws rises one BCLK before R's MSB. underrun stays 0.
- **Underrun.** No second push → frame 1 (starting at cycle 16+512) transmits 32 zero bits, underrun=1 and stays 1 across later frames until reset.
- **Backpressure.** Hold valid continuously with incrementing pairs (0x0001/0x0002, 0x0003/0x0004, …) → exactly one pair accepted per frame. sample_ready low between accept and load. Transmitted sequence is in order with no loss or duplication.
- **Reset mid-frame.** Assert reset at slot 10 of a frame → next cycle all outputs at reset values and pending dropped. After release, the next frame starts at s=0, underrun=1 if nothing is pushed.
- **Loopback.** CLK_DIV=4, W=16, L=16'h7FFF, R=16'h8000, fed into the existing I2S receive process → receiver left/right registers equal the pushed values after 2 frames.
